datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: clr  in  1  reset, synchronous, active-high.
REQ-003 SHALL have bus-drive selects, each in 1: PCout, Zlowout, Zhighout, MDRout, R2out, R3out, HIout, LOout, Cout, InPortout.
REQ-004 SHALL have register load enables, each in 1: PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, R1in, R2in, R3in.
REQ-005 SHALL have controls: Read  in  1  MDR source select; IncPC  in  1  Z op increment; DIV  in  1  Z op signed divide.
REQ-006 SHALL have MDatain  in  32  memory read data.
REQ-007 SHALL have observation outputs, each out 32: bus, pc_q, ir_q, mar_q, mdr_q, r1_q, r2_q, r3_q, hi_q, lo_q.

Function
REQ-008 SHALL hold 32-bit registers PC, IR, MAR, MDR, Y, HI, LO, R1, R2, R3, InPort, and one 64-bit register Z (Zhigh = bits 63:32, Zlow = bits 31:0).
REQ-009 SHALL form bus combinationally from the asserted select, with priority PCout > Zlowout > Zhighout > MDRout > R2out > R3out > HIout > LOout > Cout > InPortout; bus = 0 when no select is asserted.
REQ-010 Cout SHALL drive IR[18:0] sign-extended to 32 bits; InPortout SHALL drive InPort, which resets to 0 and is never loaded.
REQ-011 Each register SHALL load from bus on the rising edge where its enable is high, and SHALL hold otherwise; the enable must be high at that edge.
REQ-012 On MDRin, MDR SHALL load MDatain when Read = 1 and bus when Read = 0.
REQ-013 On Zin with DIV = 1, Z SHALL load {Y rem bus, Y / bus} using signed 32-bit division: quotient truncated toward zero, remainder carrying the sign of the dividend.
REQ-014 Divide by zero SHALL give Zlow = 32'hFFFFFFFF and Zhigh = Y.
REQ-015 Dividing 32'h80000000 by 32'hFFFFFFFF SHALL give Zlow = 32'h80000000 and Zhigh = 0.
REQ-016 On Zin with IncPC = 1 and DIV = 0, Z SHALL load {32'h0, bus + 1}, wrapping 32'hFFFFFFFF to 0.
REQ-017 On Zin with neither op asserted, Z SHALL load {32'h0, Y + bus}, modulo 2^32.
REQ-018 DIV SHALL take priority over IncPC; the divide is single-cycle, so Z is valid on the edge after Zin (latency 1).
REQ-019 A register SHALL be both read and written in the same cycle without conflict, e.g. ZlowoutPCin: the register captures the pre-edge bus value.
REQ-020 Observation outputs SHALL be continuous copies of the corresponding registers and of bus.

Reset
REQ-021 When clr = 1 at a rising edge, all registers including Z and InPort SHALL become 0, overriding every load enable in that cycle.
REQ-022 After reset, all observation outputs SHALL read 0 and bus SHALL read 0 with no selects asserted.
REQ-023 Reset asserted mid-sequence SHALL discard any in-progress operation; there is no partial state.

Verification
REQ-024 Load path: MDatain = 32'h12, Read = MDRin = 1 for one edge, then MDRout = R2in = 1 for one edge -> mdr_q = r2_q = 32'h12.
REQ-025 Fetch: PC = 0; PCout, MARin, IncPC, Zin for one edge -> mar_q = 0, Z = 1. Then Zlowout, PCin, Read, MDRin with MDatain = 32'h28918000 -> pc_q = 1, mdr_q = 32'h28918000. Then MDRout, IRin -> ir_q = 32'h28918000.
REQ-026 Divide: R2 = 32'h12, R3 = 32'h14; R2out, Yin; then R3out, DIV, Zin; then Zlowout, LOin; then Zhighout, HIin -> lo_q = 0, hi_q = 32'h12.
REQ-027 Signed/edge divide cases:
- Y = -7, bus = 2 -> lo_q = 32'hFFFFFFFD, hi_q = 32'hFFFFFFFF.
- bus = 0 -> lo_q = 32'hFFFFFFFF, hi_q = Y.
REQ-028 Priority and default: PCout and MDRout asserted together -> bus = PC. With IR = 32'h0007FFFF, Cout -> bus = 32'hFFFFFFFF.
REQ-029 Reset: load R1 = 32'h18, then assert clr together with R1in and MDRout -> all observation outputs = 0.

Source files
------------

// File: rtl/datapath.sv
// Single-bus processor datapath: register file, bus multiplexer and a Z unit that
// adds, increments or performs a single-cycle signed divide into the 64-bit Z register.
module datapath (
    input  logic        clk,
    input  logic        clr,

    input  logic        PCout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Cout,
    input  logic        InPortout,

    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,

    input  logic        Read,
    input  logic        IncPC,
    input  logic        DIV,

    input  logic [31:0] MDatain,

    output logic [31:0] bus,
    output logic [31:0] pc_q,
    output logic [31:0] ir_q,
    output logic [31:0] mar_q,
    output logic [31:0] mdr_q,
    output logic [31:0] r1_q,
    output logic [31:0] r2_q,
    output logic [31:0] r3_q,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    logic [31:0] pc_r, ir_r, mar_r, mdr_r, y_r, hi_r, lo_r;
    logic [31:0] r1_r, r2_r, r3_r, inport_r;
    logic [63:0] z_r;

    logic [31:0] c_sext;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [63:0] z_next;

    // Cout presents the 19-bit immediate field of IR, sign-extended.
    assign c_sext = {{13{ir_r[18]}}, ir_r[18:0]};

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        bus = 32'h0;
        if (PCout)          bus = pc_r;
        else if (Zlowout)   bus = z_r[31:0];
        else if (Zhighout)  bus = z_r[63:32];
        else if (MDRout)    bus = mdr_r;
        else if (R2out)     bus = r2_r;
        else if (R3out)     bus = r3_r;
        else if (HIout)     bus = hi_r;
        else if (LOout)     bus = lo_r;
        else if (Cout)      bus = c_sext;
        else if (InPortout) bus = inport_r;
    end

    // Divide by zero and the single overflowing quotient are pinned explicitly
    // rather than left to the arithmetic operator.
    always_comb begin
        div_quot = 32'h0;
        div_rem  = 32'h0;
        if (bus == 32'h0) begin
            div_quot = 32'hFFFF_FFFF;
            div_rem  = y_r;
        end else if (y_r == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
            div_quot = 32'h8000_0000;
            div_rem  = 32'h0;
        end else begin
            div_quot = $signed(y_r) / $signed(bus);
            div_rem  = $signed(y_r) % $signed(bus);
        end
    end

    always_comb begin
        z_next = {32'h0, y_r + bus};
        if (DIV)        z_next = {div_rem, div_quot};
        else if (IncPC) z_next = {32'h0, bus + 32'h1};
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge bus, which is what makes read-and-write of one register safe.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_r     <= 32'h0;
            ir_r     <= 32'h0;
            mar_r    <= 32'h0;
            mdr_r    <= 32'h0;
            y_r      <= 32'h0;
            hi_r     <= 32'h0;
            lo_r     <= 32'h0;
            r1_r     <= 32'h0;
            r2_r     <= 32'h0;
            r3_r     <= 32'h0;
            inport_r <= 32'h0;
            z_r      <= 64'h0;
        end else begin
            if (PCin)  pc_r  <= bus;
            if (IRin)  ir_r  <= bus;
            if (MARin) mar_r <= bus;
            if (MDRin) mdr_r <= Read ? MDatain : bus;
            if (Yin)   y_r   <= bus;
            if (Zin)   z_r   <= z_next;
            if (HIin)  hi_r  <= bus;
            if (LOin)  lo_r  <= bus;
            if (R1in)  r1_r  <= bus;
            if (R2in)  r2_r  <= bus;
            if (R3in)  r3_r  <= bus;
        end
    end

    assign pc_q  = pc_r;
    assign ir_q  = ir_r;
    assign mar_q = mar_r;
    assign mdr_q = mdr_r;
    assign r1_q  = r1_r;
    assign r2_q  = r2_r;
    assign r3_q  = r3_r;
    assign hi_q  = hi_r;
    assign lo_q  = lo_r;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath: each task drives one scenario and compares
// against hand-computed values.
module tb_datapath;

    logic        clk;
    logic        clr;
    logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out, HIout, LOout, Cout, InPortout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, R1in, R2in, R3in;
    logic        Read, IncPC, DIV;
    logic [31:0] MDatain;
    logic [31:0] bus, pc_q, ir_q, mar_q, mdr_q, r1_q, r2_q, r3_q, hi_q, lo_q;

    int vectors;
    int miscompares;

    datapath dut (
        .clk(clk), .clr(clr),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .InPortout(InPortout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .Read(Read), .IncPC(IncPC), .DIV(DIV),
        .MDatain(MDatain),
        .bus(bus), .pc_q(pc_q), .ir_q(ir_q), .mar_q(mar_q), .mdr_q(mdr_q),
        .r1_q(r1_q), .r2_q(r2_q), .r3_q(r3_q), .hi_q(hi_q), .lo_q(lo_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_ctrl();
        PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; R2out = 0; R3out = 0;
        HIout = 0; LOout = 0; Cout = 0; InPortout = 0;
        PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0; Zin = 0;
        HIin = 0; LOin = 0; R1in = 0; R2in = 0; R3in = 0;
        Read = 0; IncPC = 0; DIV = 0; clr = 0;
    endtask

    // Apply the currently driven controls across one rising edge, then release them.
    task automatic cycle();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        MDatain = v; Read = 1; MDRin = 1;
        cycle();
    endtask

    task automatic all_zero(input string tag);
        logic [31:0] obs [10];
        obs = '{bus, pc_q, ir_q, mar_q, mdr_q, r1_q, r2_q, r3_q, hi_q, lo_q};
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (obs[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL %s output[%0d] got %h expected 00000000", tag, i, obs[i]);
            end
        end
    endtask

    task automatic test_reset();
        clr = 1;
        cycle();
        all_zero("reset");
    endtask

    task automatic test_load_path();
        mdr_load(32'h12);
        MDRout = 1; R2in = 1;
        cycle();
        vectors++; if (mdr_q !== 32'h12) begin miscompares++; $display("FAIL load_mdr got %h expected 00000012", mdr_q); end
        vectors++; if (r2_q !== 32'h12) begin miscompares++; $display("FAIL load_r2 got %h expected 00000012", r2_q); end
        cycle();
        cycle();
        vectors++; if (r2_q !== 32'h12) begin miscompares++; $display("FAIL hold_r2 got %h expected 00000012", r2_q); end
        vectors++; if (bus !== 32'h0) begin miscompares++; $display("FAIL idle_bus got %h expected 00000000", bus); end
    endtask

    task automatic test_fetch();
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
        cycle();
        vectors++; if (mar_q !== 32'h0) begin miscompares++; $display("FAIL fetch_mar got %h expected 00000000", mar_q); end
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; MDatain = 32'h2891_8000;
        #1;
        vectors++; if (bus !== 32'h1) begin miscompares++; $display("FAIL fetch_zlow got %h expected 00000001", bus); end
        cycle();
        vectors++; if (pc_q !== 32'h1) begin miscompares++; $display("FAIL fetch_pc got %h expected 00000001", pc_q); end
        vectors++; if (mdr_q !== 32'h2891_8000) begin miscompares++; $display("FAIL fetch_mdr got %h expected 28918000", mdr_q); end
        MDRout = 1; IRin = 1;
        cycle();
        vectors++; if (ir_q !== 32'h2891_8000) begin miscompares++; $display("FAIL fetch_ir got %h expected 28918000", ir_q); end
    endtask

    task automatic test_divide_spec();
        mdr_load(32'h12); MDRout = 1; R2in = 1; cycle();
        mdr_load(32'h14); MDRout = 1; R3in = 1; cycle();
        R2out = 1; Yin = 1; cycle();
        R3out = 1; DIV = 1; Zin = 1; cycle();
        Zlowout = 1; LOin = 1; cycle();
        Zhighout = 1; HIin = 1; cycle();
        vectors++; if (lo_q !== 32'h0) begin miscompares++; $display("FAIL div_lo got %h expected 00000000", lo_q); end
        vectors++; if (hi_q !== 32'h12) begin miscompares++; $display("FAIL div_hi got %h expected 00000012", hi_q); end
    endtask

    task automatic do_div(input string tag, input logic [31:0] y, input logic [31:0] d,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic inc);
        mdr_load(y); MDRout = 1; Yin = 1; cycle();
        mdr_load(d); MDRout = 1; DIV = 1; IncPC = inc; Zin = 1; cycle();
        Zlowout = 1; LOin = 1; cycle();
        Zhighout = 1; HIin = 1; cycle();
        vectors++; if (lo_q !== exp_q) begin miscompares++; $display("FAIL %s_quot got %h expected %h", tag, lo_q, exp_q); end
        vectors++; if (hi_q !== exp_r) begin miscompares++; $display("FAIL %s_rem got %h expected %h", tag, hi_q, exp_r); end
    endtask

    task automatic test_divide_edges();
        do_div("neg7_by_2",  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div("pos7_by_m2", 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         1'b0);
        do_div("div_zero",   32'h7,         32'h0,         32'hFFFF_FFFF, 32'h7,         1'b0);
        do_div("overflow",   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0);
        do_div("div_over_inc", 32'h64,      32'h7,         32'hE,         32'h2,         1'b1);
    endtask

    task automatic test_add_inc();
        mdr_load(32'h5); MDRout = 1; Yin = 1; cycle();
        mdr_load(32'hFFFF_FFFE); MDRout = 1; Zin = 1; cycle();
        Zlowout = 1; #1;
        vectors++; if (bus !== 32'h3) begin miscompares++; $display("FAIL add_wrap got %h expected 00000003", bus); end
        clear_ctrl(); Zhighout = 1; #1;
        vectors++; if (bus !== 32'h0) begin miscompares++; $display("FAIL add_zhigh got %h expected 00000000", bus); end
        clear_ctrl();
        // Z feeds its own input: Y(5) + Zlow(3) = 8.
        Zlowout = 1; Zin = 1; cycle();
        Zlowout = 1; #1;
        vectors++; if (bus !== 32'h8) begin miscompares++; $display("FAIL add_self got %h expected 00000008", bus); end
        clear_ctrl();
        mdr_load(32'hFFFF_FFFF); MDRout = 1; IncPC = 1; Zin = 1; cycle();
        Zlowout = 1; #1;
        vectors++; if (bus !== 32'h0) begin miscompares++; $display("FAIL inc_wrap got %h expected 00000000", bus); end
        clear_ctrl();
    endtask

    task automatic test_priority();
        mdr_load(32'hABCD); MDRout = 1; PCin = 1; cycle();
        mdr_load(32'h55);
        PCout = 1; MDRout = 1; #1;
        vectors++; if (bus !== 32'hABCD) begin miscompares++; $display("FAIL prio_pc got %h expected 0000abcd", bus); end
        clear_ctrl();
        Zhighout = 1; R2out = 1; #1;
        vectors++; if (bus !== 32'h0) begin miscompares++; $display("FAIL prio_zhigh got %h expected 00000000", bus); end
        clear_ctrl();
        mdr_load(32'h0007_FFFF); MDRout = 1; IRin = 1; cycle();
        Cout = 1; #1;
        vectors++; if (bus !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cout_neg got %h expected ffffffff", bus); end
        clear_ctrl();
        mdr_load(32'hFFF3_FFFF); MDRout = 1; IRin = 1; cycle();
        Cout = 1; InPortout = 1; #1;
        vectors++; if (bus !== 32'h0003_FFFF) begin miscompares++; $display("FAIL cout_pos got %h expected 0003ffff", bus); end
        clear_ctrl();
        InPortout = 1; #1;
        vectors++; if (bus !== 32'h0) begin miscompares++; $display("FAIL inport got %h expected 00000000", bus); end
        clear_ctrl();
    endtask

    task automatic test_reset_mid();
        mdr_load(32'h18); MDRout = 1; R1in = 1; cycle();
        vectors++; if (r1_q !== 32'h18) begin miscompares++; $display("FAIL r1_load got %h expected 00000018", r1_q); end
        mdr_load(32'h99); MDRout = 1; Yin = 1; Zin = 1; cycle();
        clr = 1; R1in = 1; MDRout = 1; Zin = 1; cycle();
        all_zero("mid_reset");
        Zlowout = 1; #1;
        vectors++; if (bus !== 32'h0) begin miscompares++; $display("FAIL reset_zlow got %h expected 00000000", bus); end
        clear_ctrl();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        MDatain = 32'h0;
        clear_ctrl();
        test_reset();
        test_load_path();
        test_fetch();
        test_divide_spec();
        test_divide_edges();
        test_add_inc();
        test_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
